// File: rtl/core_pkg.sv
// Constants shared by the core front end: reset vector, canonical NOP and the
// low-order mask that keeps fetch addresses word aligned.
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue of {pc, instruction} pairs. Entry 0 is always the head,
// so the decode-facing outputs come straight from flops.
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push_valid,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic            do_pop;
    logic            do_push;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   count_next;

    assign do_pop     = pop && head_valid;
    assign do_push    = push_valid && ((count < CW'(DEPTH)) || do_pop);
    assign wr_idx     = do_pop ? count - CW'(1) : count;
    assign count_next = count + CW'(do_push) - CW'(do_pop);

    assign head_pc    = pc_q[0];
    assign head_data  = data_q[0];

    // Popping shifts every entry toward the head; a simultaneous push lands in
    // the slot just vacated at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
            count      <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_q[i]   <= pc_q[i+1];
                    data_q[i] <= data_q[i+1];
                end
            end
            if (do_push) begin
                pc_q[wr_idx[AW-1:0]]   <= push_pc;
                data_q[wr_idx[AW-1:0]] <= push_data;
            end
            count      <= count_next;
            head_valid <= (count_next != '0);
        end
    end

    always @(posedge clk) begin
        if (rst && push_valid && !flush)
            assert (count < CW'(DEPTH) || do_pop);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential word fetches under
// a credit limit, tags responses with their PC and squashes stale ones on redirect.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fq_count;
    logic            out_of_reset;
    logic [CW:0]     credits_used;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_keep;
    logic [XLEN-1:0] target;

    assign target = redirect_pc & ~XLEN'(ALIGN_MASK);

    // Queued entries plus live (non-discarded) requests must never exceed the
    // queue size, so every response that survives always finds a free slot.
    assign credits_used   = {1'b0, fq_count} + {1'b0, inflight} - {1'b0, discard};
    assign imem_req_valid = out_of_reset && !redirect_valid
                            && (credits_used < (CW+1)'(FQ_DEPTH))
                            && (inflight < CW'(FQ_DEPTH));
    assign imem_req_addr  = pc;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_accept = imem_rsp_valid && (inflight != '0);
    assign rsp_keep   = rsp_accept && (discard == '0) && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            head_pc      <= RESET_PC;
            inflight     <= '0;
            discard      <= '0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (redirect_valid) begin
                pc       <= target;
                head_pc  <= target;
                inflight <= inflight - CW'(rsp_accept);
                discard  <= inflight - CW'(rsp_accept);
            end else begin
                if (req_fire)
                    pc <= pc + XLEN'(4);
                inflight <= inflight + CW'(req_fire) - CW'(rsp_accept);
                if (rsp_accept) begin
                    if (discard != '0)
                        discard <= discard - CW'(1);
                    else
                        head_pc <= head_pc + XLEN'(4);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst && imem_rsp_valid)
            assert (inflight != '0);
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push_valid (rsp_keep),
        .push_pc    (head_pc),
        .push_data  (imem_rsp_data),
        .pop        (inst_ready),
        .head_valid (inst_valid),
        .head_pc    (inst_pc),
        .head_data  (inst_data),
        .count      (fq_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with variable
// latency plus a PC-stream reference (what decode must see after each redirect).
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          req_rdy_pct  = 100;
    int          inst_rdy_pct = 100;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    bit          fired, popped, rsp_now;
    logic [31:0] fire_addr, pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic apply_stimulus(input bit redir, input logic [31:0] tgt);
        int d;
        imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        inst_ready     = ($urandom_range(99) < inst_rdy_pct);
        rsp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cycle);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        fired  = imem_req_valid && imem_req_ready;
        popped = inst_valid && inst_ready && !redir;
        if (redir)
            check_output("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        if (fired) begin
            fire_addr = imem_req_addr;
            check_output("req_addr", imem_req_addr, exp_req);
        end
        if (popped) begin
            pop_pc = inst_pc;
            check_output("inst_pc", inst_pc, exp_pc);
            check_output("inst_data", inst_data, mem_word(exp_pc));
        end
        @(posedge clk);
        if (rsp_now)
            void'(mem_q.pop_front());
        if (fired) begin
            d = cycle + $urandom_range(lat_max, lat_min);
            if (d <= last_due)
                d = last_due + 1;
            last_due = d;
            mem_q.push_back('{fire_addr, d});
        end
        if (redir) begin
            exp_req = tgt & 32'hFFFF_FFFC;
            exp_pc  = tgt & 32'hFFFF_FFFC;
        end else begin
            if (fired)  exp_req = exp_req + 32'd4;
            if (popped) exp_pc  = exp_pc + 32'd4;
        end
        cycle++;
        check_output("outstanding_le_depth", 32'(mem_q.size() <= DEPTH), 32'd1);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge (between active edges) and checks outputs at once.
    task automatic do_reset();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        #1;
        check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("rst_req_addr", imem_req_addr, 32'h0);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_inst_data", inst_data, 32'h0);
        check_output("rst_inst_pc", inst_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_q.delete();
        last_due = cycle;
        exp_req  = 32'h0;
        exp_pc   = 32'h0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int fires, pops, k;
        logic [31:0] a0, a1;
        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // 1-cycle memory, always-ready consumer: one instruction per cycle.
        lat_min = 1; lat_max = 1; req_rdy_pct = 100; inst_rdy_pct = 100;
        apply_stimulus(0, 0);
        check_output("req_valid_after_reset", 32'(imem_req_valid), 32'd1);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 0);
            if (popped) pops++;
        end
        check_output("stream_pop_count", 32'(pops), 32'd18);

        // Decode stalled: exactly DEPTH requests, then fetch stops.
        do_reset();
        inst_rdy_pct = 0;
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(0, 0);
            if (fired) fires++;
        end
        check_output("stall_fire_count", 32'(fires), 32'd4);
        check_output("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("stall_inst_valid", 32'(inst_valid), 32'd1);
        inst_rdy_pct = 100;
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) apply_stimulus(0, 0);
        check_output("resume_fire_seen", 32'(fired), 32'd1);
        check_output("resume_addr", fire_addr, 32'h10);
        repeat (12) apply_stimulus(0, 0);

        // 3-cycle memory, redirect with three requests in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mem_q.size() < 3; i++) apply_stimulus(0, 0);
        check_output("three_in_flight", 32'(mem_q.size()), 32'd3);
        apply_stimulus(1, 32'h0000_0203);
        check_output("redirect_clears_head", 32'(inst_valid), 32'd0);
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) apply_stimulus(0, 0);
        check_output("redirect_first_addr", fire_addr, 32'h200);
        popped = 0;
        k = 1;
        for (int i = 0; i < 20 && !popped; i++) begin
            apply_stimulus(0, 0);
            k++;
        end
        check_output("redirect_first_pc", pop_pc, 32'h200);
        check_output("redirect_latency_ge5", 32'(k >= 5), 32'd1);

        // Redirect in the same cycle that a response arrives.
        lat_min = 2; lat_max = 2;
        repeat (4) apply_stimulus(0, 0);
        for (int i = 0; i < 20 && !(mem_q.size() > 0 && mem_q[0].due <= cycle); i++)
            apply_stimulus(0, 0);
        check_output("rsp_due_at_redirect", 32'(mem_q.size() > 0 && mem_q[0].due <= cycle), 32'd1);
        apply_stimulus(1, 32'h0000_0400);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 0);
            if (popped) pops++;
        end
        check_output("after_same_cycle_redirect_progress", 32'(pops > 0), 32'd1);

        // Random ready handshakes, variable latency and occasional redirects.
        lat_min = 1; lat_max = 4; req_rdy_pct = 60; inst_rdy_pct = 50;
        pops = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 2) apply_stimulus(1, $urandom);
            else                        apply_stimulus(0, 0);
            if (popped) pops++;
        end
        check_output("random_progress", 32'(pops > 100), 32'd1);

        // Address wrap at the top of the address space.
        lat_min = 1; lat_max = 1; req_rdy_pct = 100; inst_rdy_pct = 100;
        apply_stimulus(1, 32'hFFFF_FFFE);
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) apply_stimulus(0, 0);
        a0 = fire_addr;
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) apply_stimulus(0, 0);
        a1 = fire_addr;
        check_output("wrap_first_addr", a0, 32'hFFFF_FFFC);
        check_output("wrap_second_addr", a1, 32'h0000_0000);
        repeat (10) apply_stimulus(0, 0);

        // Reset in the middle of a burst, then refetch from the reset vector.
        check_output("burst_active_before_reset", 32'(inst_valid), 32'd1);
        do_reset();
        apply_stimulus(0, 0);
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) apply_stimulus(0, 0);
        check_output("refetch_addr", fire_addr, 32'h0);
        repeat (10) apply_stimulus(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core. It owns the PC register and issues sequential instruction-memory requests. Each response is tagged with its PC and buffered in a small in-order fetch queue for decode. Redirects from branch/jump resolution flush the queue, squash in-flight responses and restart fetch at the new target, decoupling fetch from decode stalls and variable memory latency.

## Interface
- XLEN, 32: address/instruction width (≥32, multiple of 8)
- RESET_PC, 0: PC loaded on reset (XLEN bits, word-aligned)
- FQ_DEPTH, 4: fetch-queue entries, power of two ≥2; also maximum outstanding requests
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- imem_req_valid  out  1  request address valid
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  in-order response data valid (no back-pressure; always accepted)
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  restart fetch at redirect_pc
- redirect_pc  in  XLEN  new target; bits [1:0] forced to 0 internally
- inst_valid  out  1  queue head valid
- inst_data  out  XLEN  queue head instruction
- inst_pc  out  XLEN  PC of queue head
- inst_ready  in  1  decode consumes head this cycle

## Operation
- State: pc (next request address); head_pc (PC of oldest live outstanding request); inflight (requests issued and not yet answered, 0..FQ_DEPTH); discard (responses still to drop, ≤ inflight); queue count.
- Issue: imem_req_valid = !redirect_valid && (count + inflight − discard) < FQ_DEPTH && inflight < FQ_DEPTH. On valid&&ready: pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
- Response: inflight −= 1. If discard > 0, discard −= 1 and the data is dropped. Otherwise push {head_pc, data} and head_pc += 4.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle keep count unchanged and are legal when full.
- Redirect (priority over everything):
  - Queue is cleared and pc = head_pc = redirect_pc & ~3.
  - discard = inflight − (1 if a response arrives this cycle, else 0); the arriving response is dropped.
  - No request is issued this cycle; inst_ready is ignored.
- The credit rule guarantees every live response has a free queue slot. A push while full is impossible; assert on it in simulation.
- imem_rsp_valid with inflight == 0 is a protocol error; assert, and ignore the response.

## Timing
- Reset values:
  - imem_req_valid 0 while rst low, 1 from the first cycle after release.
  - imem_req_addr = RESET_PC.
  - inst_valid 0; inst_data 0; inst_pc 0.
  - inflight, discard and count all 0.
- imem_req_addr is driven from the pc register; no combinational path from imem_req_ready.
- Queue output is registered: a response at edge t gives inst_valid = 1 after edge t, so memory-to-decode latency is 1 cycle.
- Redirect at edge t:
  - inst_valid = 0 after edge t.
  - First request to the new target issues in cycle t+1.
  - The first new instruction reaches decode no earlier than t+1 + memory latency + 1.
- Back-to-back redirects are legal; each reloads discard from the current inflight.
- Reset asserted mid-operation clears all state immediately; responses after release with inflight == 0 follow the protocol-error rule above.

## Structure
- Shared package core_pkg holds RESET_PC_DEFAULT, the INST_NOP encoding, and the alignment mask constant.
- One sub-module, fetch_queue: a synchronous FIFO of FQ_DEPTH×(2·XLEN) with registered head, count output, and a synchronous flush input.
- Counter widths are $clog2(FQ_DEPTH)+1.

## Test plan
- Reset, imem_req_ready = 1, 1-cycle memory, inst_ready = 1 → addresses 0,4,8,… and inst_pc 0,4,8,… in order with matching data.
- inst_ready = 0 with FQ_DEPTH = 4 → exactly 4 requests issued and 4 entries queued, then imem_req_valid stays 0; releasing inst_ready resumes at 0x10.
- 3-cycle memory, 3 requests in flight, redirect to 0x203 → next request 0x200, all 3 old responses dropped, first inst_pc 0x200.
- Redirect in the same cycle as a response → that response is dropped, discard = inflight − 1, and no stale PC reaches decode.
- imem_req_ready toggling randomly plus random inst_ready → PCs contiguous, no loss or duplication, count ≤ FQ_DEPTH.
- pc = 0xFFFFFFFC → next request 0x00000000; rst asserted mid-burst → outputs at reset values immediately, and refetch starts at RESET_PC.
